// File: rtl/data_mem_lsu_pkg.sv
// Shared core types for the data memory / load-store unit.
package data_mem_lsu_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned DMEM_WAIT_MAX = 15;
    localparam int unsigned DMEM_CNT_W    = 4;

    // RISC-V load/store size encodings; stores reuse the load codes
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } mem_funct3_e;

    localparam mem_funct3_e SB = LB;
    localparam mem_funct3_e SH = LH;
    localparam mem_funct3_e SW = LW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    // 32-bit data bus with byte and halfword lane views
    typedef union packed {
        logic [XLEN-1:0]  word;
        logic [1:0][15:0] half;
        logic [3:0][7:0]  lane;
    } dataBus_u;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store replication/byte enables and load shift/extension.
module lsu_align
    import data_mem_lsu_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_addr_lo,
    input  dataBus_u   i_store_data,
    input  dataBus_u   i_load_word,
    output dataBus_u   o_store_data_c,
    output logic [3:0] o_byte_en_c,
    output dataBus_u   o_load_data_c,
    output logic       o_misaligned_c
);

    logic [7:0]  w_lane;
    logic [15:0] w_half;
    logic        w_zext;

    assign w_lane = i_load_word.lane[i_addr_lo];
    assign w_half = i_load_word.half[i_addr_lo[1]];
    assign w_zext = i_funct3[2];

    // Decode size into lane selection; reserved codes fall through as misaligned
    always_comb begin
        o_store_data_c = i_store_data;
        o_byte_en_c    = 4'b0000;
        o_load_data_c  = i_load_word;
        o_misaligned_c = 1'b1;
        case (i_funct3)
            LB, LBU: begin
                o_misaligned_c      = 1'b0;
                o_store_data_c.word = {4{i_store_data.lane[0]}};
                o_byte_en_c         = 4'b0001 << i_addr_lo;
                o_load_data_c.word  = w_zext ? {24'b0, w_lane} : {{24{w_lane[7]}}, w_lane};
            end
            LH, LHU: begin
                o_misaligned_c      = i_addr_lo[0];
                o_store_data_c.word = {2{i_store_data.half[0]}};
                o_byte_en_c         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_load_data_c.word  = w_zext ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            LW: begin
                o_misaligned_c = (i_addr_lo != 2'b00);
                o_byte_en_c    = 4'b1111;
            end
            default: ;
        endcase
        // A rejected access never touches memory
        if (o_misaligned_c) begin
            o_byte_en_c = 4'b0000;
        end
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with wait-state LSU front end for the MEM stage.
module data_mem_lsu
    import data_mem_lsu_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       data_rd_en,
    input  logic       data_wr_en,
    input  logic [2:0] funct3,
    input  logic [31:0] addr,
    input  dataBus_u   data_in,
    output dataBus_u   data_out,
    output logic       data_ready,
    output logic       misaligned,
    output logic       busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
        DMEM_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    dmem_state_e           r_state;
    logic [DMEM_CNT_W-1:0] r_cnt;
    logic [AW+1:0]         r_addr;
    logic [2:0]            r_funct3;
    dataBus_u              r_wdata;
    logic                  r_is_store;
    logic                  r_busy;
    logic                  r_data_ready;
    logic                  r_misaligned;
    dataBus_u              r_data_out;
    logic [XLEN-1:0]       r_mem [DEPTH];

    logic [AW-1:0] w_idx;
    dataBus_u      w_rword;
    dataBus_u      w_store;
    dataBus_u      w_load;
    logic [3:0]    w_byte_en;
    logic          w_misaligned;
    logic          w_req;
    logic          w_unused_addr;

    assign w_idx         = r_addr[AW+1:2];
    assign w_rword       = r_mem[w_idx];
    assign w_req         = data_rd_en | data_wr_en;
    assign w_unused_addr = ^addr[31:AW+2];

    assign data_out   = r_data_out;
    assign data_ready = r_data_ready;
    assign misaligned = r_misaligned;
    assign busy       = r_busy;

    lsu_align u_align (
        .i_funct3       (r_funct3),
        .i_addr_lo      (r_addr[1:0]),
        .i_store_data   (r_wdata),
        .i_load_word    (w_rword),
        .o_store_data_c (w_store),
        .o_byte_en_c    (w_byte_en),
        .o_load_data_c  (w_load),
        .o_misaligned_c (w_misaligned)
    );

    // Request FSM: accept, count wait states, complete with a one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_funct3     <= '0;
            r_wdata      <= '0;
            r_is_store   <= 1'b0;
            r_busy       <= 1'b0;
            r_data_ready <= 1'b0;
            r_misaligned <= 1'b0;
            r_data_out   <= '0;
        end else if (clk_en) begin
            r_data_ready <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                IDLE: begin
                    // busy still high marks the data_ready cycle; the held request is stale
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (w_req) begin
                        r_addr     <= addr[AW+1:0];
                        r_funct3   <= funct3;
                        r_wdata    <= data_in;
                        r_is_store <= data_wr_en;
                        r_busy     <= 1'b1;
                        r_cnt      <= CNT_INIT;
                        r_state    <= (WAIT_STATES > 0) ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - DMEM_CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_data_ready <= 1'b1;
                    r_misaligned <= w_misaligned;
                    if (!r_is_store && !w_misaligned) begin
                        r_data_out <= w_load;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Storage write port: enabled lanes only, committed at the end of DONE
    always_ff @(posedge clk) begin
        if (clk_en && (r_state == DONE) && r_is_store && !w_misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_store.lane[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu (DEPTH=1024, WAIT_STATES=1).
module tb_data_mem_lsu;
    import data_mem_lsu_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS    = 1;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        data_rd_en;
    logic        data_wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr;
    dataBus_u    data_in;
    dataBus_u    data_out;
    logic        data_ready;
    logic        misaligned;
    logic        busy;

    typedef struct {
        logic [31:0] d;
        logic        m;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] exp_dout = 32'h0;

    data_mem_lsu #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .data_rd_en (data_rd_en),
        .data_wr_en (data_wr_en),
        .funct3     (funct3),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_ready (data_ready),
        .misaligned (misaligned),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop one expectation per completion pulse
    always @(negedge clk) begin
        if (data_ready) begin
            chk("completion expected by scoreboard", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("data_out", data_out.word, e.d);
                chk("misaligned", {31'b0, misaligned}, {31'b0, e.m});
                chk("data_ready latency", 32'(cyc), 32'(e.due));
                chk("busy during data_ready", {31'b0, busy}, 32'd1);
            end
        end else begin
            chk("misaligned without data_ready", {31'b0, misaligned}, 32'd0);
        end
    end

    task automatic drop_req();
        data_rd_en   = 1'b0;
        data_wr_en   = 1'b0;
        funct3       = 3'b000;
        addr         = 32'h0;
        data_in.word = 32'h0;
    endtask

    // mode 0 normal, 1 clk_en pause in WAIT, 2 inputs changed while busy, 3 reset in WAIT
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] ld_val, input bit m, input int mode);
        bit   acc;
        bit   b0;
        int   due;
        exp_t x;
        @(negedge clk);
        data_rd_en   = rd;
        data_wr_en   = wr;
        funct3       = f3;
        addr         = a;
        data_in.word = d;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            b0 = busy;
            @(posedge clk);
            #1;
            if (busy && !b0) acc = 1'b1;
        end
        if (!acc) begin
            chk("accept timeout", 32'd0, 32'd1);
            drop_req();
            return;
        end
        due = cyc + int'(WS) + 1 + ((mode == 1) ? 3 : 0);
        if (mode == 3) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("reset data_out", data_out.word, 32'h0);
            chk("reset data_ready", {31'b0, data_ready}, 32'd0);
            chk("reset misaligned", {31'b0, misaligned}, 32'd0);
            chk("reset busy", {31'b0, busy}, 32'd0);
            exp_dout = 32'h0;
            @(negedge clk);
            drop_req();
            rst_n = 1'b1;
            return;
        end
        if (rd && !wr && !m) exp_dout = ld_val;
        x.d   = exp_dout;
        x.m   = m;
        x.due = due;
        sb.push_back(x);
        if (mode == 1) begin
            @(negedge clk);
            clk_en = 1'b0;
            repeat (3) @(negedge clk);
            clk_en = 1'b1;
        end else if (mode == 2) begin
            @(negedge clk);
            data_rd_en   = 1'b0;
            data_wr_en   = 1'b1;
            funct3       = 3'b010;
            data_in.word = 32'hFFFF_FFFF;
        end
        acc = 1'b0;
        for (int k = 0; k < 30 && !acc; k++) begin
            @(negedge clk);
            if (data_ready) acc = 1'b1;
        end
        if (!acc) chk("data_ready timeout", 32'd0, 32'd1);
        drop_req();
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        issue(1'b0, 1'b1, f3, a, d, 32'h0, 1'b0, 0);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v);
        issue(1'b1, 1'b0, f3, a, 32'h0, v, 1'b0, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        clk_en = 1'b1;
        drop_req();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init data_out", data_out.word, 32'h0);
        chk("init data_ready", {31'b0, data_ready}, 32'd0);
        chk("init misaligned", {31'b0, misaligned}, 32'd0);
        chk("init busy", {31'b0, busy}, 32'd0);

        st(3'b010, 32'h10, 32'hDEAD_BEEF);
        ld(3'b010, 32'h10, 32'hDEAD_BEEF);
        st(3'b000, 32'h13, 32'hAAAA_AA80);
        ld(3'b000, 32'h13, 32'hFFFF_FF80);
        ld(3'b100, 32'h13, 32'h0000_0080);
        ld(3'b010, 32'h10, 32'h80AD_BEEF);

        st(3'b010, 32'h20, 32'h0);
        st(3'b001, 32'h22, 32'hFFFF_1234);
        ld(3'b010, 32'h20, 32'h1234_0000);
        ld(3'b001, 32'h22, 32'h0000_1234);
        st(3'b001, 32'h20, 32'h0000_8001);
        ld(3'b001, 32'h20, 32'hFFFF_8001);
        ld(3'b101, 32'h20, 32'h0000_8001);
        ld(3'b010, 32'h20, 32'h1234_8001);

        st(3'b010, 32'h04, 32'h1122_3344);
        issue(1'b1, 1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, 0);
        issue(1'b0, 1'b1, 3'b001, 32'h05, 32'hBEEF, 32'h0, 1'b1, 0);
        issue(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        issue(1'b0, 1'b1, 3'b110, 32'h04, 32'h0, 32'h0, 1'b1, 0);
        ld(3'b010, 32'h04, 32'h1122_3344);

        st(3'b010, 32'h1000, 32'hA5A5_A5A5);
        ld(3'b010, 32'h0, 32'hA5A5_A5A5);
        ld(3'b010, 32'h1010, 32'h80AD_BEEF);

        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, 1);
        issue(1'b1, 1'b0, 3'b010, 32'h04, 32'h0, 32'h1122_3344, 1'b0, 2);
        ld(3'b010, 32'h04, 32'h1122_3344);

        issue(1'b1, 1'b1, 3'b010, 32'h30, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
        ld(3'b010, 32'h30, 32'h0BAD_F00D);

        st(3'b010, 32'h40, 32'hCAFE_F00D);
        ld(3'b010, 32'h40, 32'hCAFE_F00D);
        issue(1'b0, 1'b1, 3'b010, 32'h40, 32'h55, 32'h0, 1'b0, 3);
        repeat (5) @(negedge clk);
        ld(3'b010, 32'h40, 32'hCAFE_F00D);

        repeat (4) @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
